// File: rtl/psum_buffer_ctrl_pkg.sv
// Shared definitions for the psum buffer: default geometry and read FSM encoding.
// The read FSM encoding is fixed because the controller decodes it.
package psum_buffer_ctrl_pkg;

    localparam int PSUM_WIDTH_DEF = 16;
    localparam int PSUM_DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/psum_buffer_ctrl_mem.sv
// psum_mem: DEPTH x WIDTH register array with one write port and one registered read-first port.
// With PSUM_ACC_EN the current write-address contents are also exposed for read-modify-write.
module psum_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
`ifdef PSUM_ACC_EN
    ,
    output logic [WIDTH-1:0] wold
`endif
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive both resets; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata <= '0;
        else if (clr)   rdata <= '0;
        else if (re)    rdata <= mem[raddr];
    end

`ifdef PSUM_ACC_EN
    assign wold = mem[waddr];
`endif

endmodule

// File: rtl/psum_buffer_ctrl.sv
// Partial-sum scratchpad controller: read FSM, read/write pointers, written flags, write-wrap flag.
// Define PSUM_ACC_EN to accumulate into the buffer (first_time selects store vs add).
module psum_buffer_ctrl
    import psum_buffer_ctrl_pkg::*;
#(
    parameter int PSUM_DEPTH      = PSUM_DEPTH_DEF,
    parameter int PSUM_ADDR_WIDTH = $clog2(PSUM_DEPTH),
    parameter int PSUM_WIDTH      = PSUM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  global_rst,
    input  logic                  psum_buffer_ren,
    input  logic                  next_psum_raddr,
    input  logic                  rst_psum_raddr,
    input  logic                  next_psum_waddr,
    input  logic                  first_time,
    input  logic                  wen,
    input  logic [PSUM_WIDTH-1:0] wdata,
    output logic [PSUM_WIDTH-1:0] psum_rdata,
    output logic                  psum_buffer_valid,
    output logic                  can_read_psum,
    output logic                  psum_w_co,
    output logic                  error
);

    rd_state_e                  state, state_nxt;
    logic [PSUM_ADDR_WIDTH-1:0] raddr, waddr, fetch_addr;
    logic [PSUM_DEPTH-1:0]      written;
    logic                       rd_accept, rd_err, wr_ok, acc_err, error_nxt;
    logic [PSUM_WIDTH-1:0]      wr_val;

    assign can_read_psum     = written[raddr] & (state == R_IDLE);
    assign psum_buffer_valid = (state == R_HOLD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          state <= R_IDLE;
        else if (global_rst) state <= R_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_accept = 1'b0;
        rd_err    = 1'b0;
        case (state)
            R_IDLE: begin
                if (psum_buffer_ren) begin
                    if (can_read_psum) begin
                        rd_accept = 1'b1;
                        state_nxt = R_FETCH;
                    end else begin
                        rd_err = 1'b1;
                    end
                end
            end
            R_FETCH: state_nxt = R_HOLD;
            R_HOLD:  if (next_psum_raddr || rst_psum_raddr) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    assign wr_ok = wen & ~psum_w_co;

`ifdef PSUM_ACC_EN
    logic [PSUM_WIDTH-1:0] wold;
    // Accumulating into a never-written entry is flagged but still stores the raw value.
    assign acc_err = wen & ~first_time & ~written[waddr];
    assign wr_val  = (first_time || !written[waddr]) ? wdata : wold + wdata;
`else
    logic unused_first_time;
    assign unused_first_time = first_time;
    assign acc_err = 1'b0;
    assign wr_val  = wdata;
`endif

    assign error_nxt = rd_err | (wen & psum_w_co) | acc_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raddr      <= '0;
            waddr      <= '0;
            fetch_addr <= '0;
            written    <= '0;
            psum_w_co  <= 1'b0;
            error      <= 1'b0;
        end else if (global_rst) begin
            raddr      <= '0;
            waddr      <= '0;
            fetch_addr <= '0;
            written    <= '0;
            psum_w_co  <= 1'b0;
            error      <= 1'b0;
        end else begin
            error <= error_nxt;
            if (rd_accept) fetch_addr <= raddr;
            if (rst_psum_raddr)       raddr <= '0;
            else if (next_psum_raddr) raddr <= raddr + 1'b1;
            if (wr_ok) written[waddr] <= 1'b1;
            // The write above uses the pre-increment address.
            if (next_psum_waddr) begin
                waddr <= waddr + 1'b1;
                if (&waddr) psum_w_co <= 1'b1;
            end
        end
    end

    psum_mem #(
        .DEPTH (PSUM_DEPTH),
        .AW    (PSUM_ADDR_WIDTH),
        .WIDTH (PSUM_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst_n (reset),
        .clr   (global_rst),
        .we    (wr_ok & ~global_rst),
        .waddr (waddr),
        .wdata (wr_val),
        .re    (state == R_FETCH),
        .raddr (fetch_addr),
        .rdata (psum_rdata)
`ifdef PSUM_ACC_EN
        ,
        .wold  (wold)
`endif
    );

endmodule

// File: tb/tb_psum_buffer_ctrl.sv
// Scoreboard bench for psum_buffer_ctrl: directed scenarios then randomized traffic against a queue/array model.
module tb_psum_buffer_ctrl;

    localparam int D = 16;
    localparam int W = 16;
`ifdef PSUM_ACC_EN
    localparam logic [W-1:0] T5_EXP = 16'd12;
`else
    localparam logic [W-1:0] T5_EXP = 16'd5;
`endif

    logic         clk = 1'b0;
    logic         reset, global_rst, ren, nxr, rsr, nxw, ft, wen;
    logic [W-1:0] wdata;
    logic [W-1:0] psum_rdata;
    logic         valid, can, wco, error;

    always #5 clk = ~clk;

    psum_buffer_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .global_rst        (global_rst),
        .psum_buffer_ren   (ren),
        .next_psum_raddr   (nxr),
        .rst_psum_raddr    (rsr),
        .next_psum_waddr   (nxw),
        .first_time        (ft),
        .wen               (wen),
        .wdata             (wdata),
        .psum_rdata        (psum_rdata),
        .psum_buffer_valid (valid),
        .can_read_psum     (can),
        .psum_w_co         (wco),
        .error             (error)
    );

    // Reference model: buffer contents, written flags, pointers and read phase (0 idle, 1 fetch, 2 hold)
    logic [W-1:0] m_mem [D];
    bit           m_wr  [D];
    int           m_raddr, m_waddr, m_phase, m_faddr;
    bit           m_wco;
    logic [W-1:0] exp_q [$];
    int           err_q [$];
    int           cyc;
    int           checks, errors;
    bit           mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void m_clear();
        m_raddr = 0;
        m_waddr = 0;
        m_phase = 0;
        m_faddr = 0;
        m_wco   = 1'b0;
        foreach (m_wr[i]) m_wr[i] = 1'b0;
    endfunction

    task automatic m_step();
        bit           err = 1'b0;
        logic [W-1:0] v;
        if (global_rst) begin
            m_clear();
            return;
        end
        case (m_phase)
            0: if (ren) begin
                   if (m_wr[m_raddr]) begin m_phase = 1; m_faddr = m_raddr; end
                   else err = 1'b1;
               end
            1: begin exp_q.push_back(m_mem[m_faddr]); m_phase = 2; end
            default: if (nxr || rsr) m_phase = 0;
        endcase
        if (rsr)      m_raddr = 0;
        else if (nxr) m_raddr = (m_raddr + 1) % D;
        if (wen) begin
            if (m_wco) err = 1'b1;
            else begin
                v = wdata;
`ifdef PSUM_ACC_EN
                if (!ft) begin
                    if (m_wr[m_waddr]) v = m_mem[m_waddr] + wdata;
                    else err = 1'b1;
                end
`endif
                m_mem[m_waddr] = v;
                m_wr[m_waddr]  = 1'b1;
            end
        end
        if (nxw) begin
            if (m_waddr == D - 1) begin m_waddr = 0; m_wco = 1'b1; end
            else m_waddr++;
        end
        if (err) err_q.push_back(cyc);
    endtask

    // One clock: compare state-derived outputs, drive, step model at the edge, return at negedge.
    task automatic tick(input bit gr, input bit r, input bit nr, input bit rr,
                        input bit nw, input bit f, input bit we, input logic [W-1:0] d);
        check("can_read_psum", 32'(can), 32'(m_phase == 0 && m_wr[m_raddr]));
        check("psum_buffer_valid", 32'(valid), 32'(m_phase == 2));
        check("psum_w_co", 32'(wco), 32'(m_wco));
        global_rst = gr; ren = r; nxr = nr; rsr = rr; nxw = nw; ft = f; wen = we; wdata = d;
        @(posedge clk);
        cyc++;
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        tick(0, 0, 0, 0, 0, 0, 0, '0);
    endtask

    // Monitor: pops expected read data when valid rises, expected error pulses by cycle stamp
    initial begin
        bit           pv;
        bit           eexp;
        logic [W-1:0] held;
        pv   = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pv = 1'b0;
                continue;
            end
            if (valid && !pv) begin
                if (exp_q.size() == 0) check("read_unexpected", 32'(valid), 32'd0);
                else begin
                    held = exp_q.pop_front();
                    check("read_data", 32'(psum_rdata), 32'(held));
                end
            end else if (valid) begin
                check("read_hold_stable", 32'(psum_rdata), 32'(held));
            end
            pv = valid;
            eexp = (err_q.size() > 0 && err_q[0] == cyc);
            if (error || eexp) begin
                check("error_pulse", 32'(error), 32'(eexp));
                if (eexp) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; mon_en = 1'b0;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_clear();
        reset = 1'b0; global_rst = 0; ren = 0; nxr = 0; rsr = 0; nxw = 0; ft = 0; wen = 0; wdata = '0;
        #2;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_can", 32'(can), 32'd0);
        check("rst_wco", 32'(wco), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_rdata", 32'(psum_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // T1: fill entries 0..3 (write with pointer advance), read entry 0
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 1, 1, 16'h0011);
        tick(0, 1, 0, 0, 0, 0, 0, '0);
        check("t1_valid_early", 32'(valid), 32'd0);
        idle();
        check("t1_valid", 32'(valid), 32'd1);
        check("t1_rdata", 32'(psum_rdata), 32'h0011);

        // T2: consume from hold
        tick(0, 0, 1, 0, 0, 0, 0, '0);
        check("t2_valid_drop", 32'(valid), 32'd0);
        check("t2_can_read", 32'(can), 32'd1);

        // T3: read of a never-written entry
        tick(1, 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0, 0, 0, 0, '0);
        tick(0, 1, 0, 0, 0, 0, 0, '0);
        check("t3_error", 32'(error), 32'd1);
        check("t3_valid", 32'(valid), 32'd0);
        idle();
        check("t3_error_pulse_end", 32'(error), 32'd0);
        check("t3_valid_idle", 32'(valid), 32'd0);

        // T4: write entry 0, wrap write pointer, blocked write, both read-pointer controls together
        tick(0, 0, 0, 0, 1, 1, 1, 16'h1234);
        for (int i = 0; i < 15; i++) tick(0, 0, 0, 0, 1, 0, 0, '0);
        check("t4_wco", 32'(wco), 32'd1);
        tick(0, 0, 0, 0, 0, 1, 1, 16'hBEEF);
        check("t4_wr_error", 32'(error), 32'd1);
        tick(0, 0, 1, 1, 0, 0, 0, '0);
        check("t4_can_raddr0", 32'(can), 32'd1);
        tick(0, 1, 0, 0, 0, 0, 0, '0);
        idle();
        check("t4_entry0_kept", 32'(psum_rdata), 32'h1234);
        tick(0, 0, 1, 0, 0, 0, 0, '0);

        // T5: first-time write then follow-up write to entry 2
        tick(1, 0, 0, 0, 0, 0, 0, '0);
        tick(0, 0, 0, 0, 1, 0, 0, '0);
        tick(0, 0, 0, 0, 1, 0, 0, '0);
        tick(0, 0, 0, 0, 0, 1, 1, 16'd7);
        tick(0, 0, 0, 0, 0, 0, 1, 16'd5);
        tick(0, 0, 1, 0, 0, 0, 0, '0);
        tick(0, 0, 1, 0, 0, 0, 0, '0);
        tick(0, 1, 0, 0, 0, 0, 0, '0);
        idle();
        check("t5_rdata", 32'(psum_rdata), 32'(T5_EXP));

        // T6: async reset while holding
        mon_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("t6_valid_async", 32'(valid), 32'd0);
        check("t6_can", 32'(can), 32'd0);
        check("t6_rdata", 32'(psum_rdata), 32'd0);
        m_clear();
        exp_q.delete();
        err_q.delete();
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 1, 1, 16'hABCD);
        tick(0, 1, 0, 0, 0, 0, 0, '0);
        idle();
        check("t6_ptrs_zero", 32'(psum_rdata), 32'hABCD);
        tick(0, 0, 1, 0, 0, 0, 0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(99) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
                 $urandom_range(9) == 0, $urandom_range(3) == 0, $urandom_range(1) == 0,
                 $urandom_range(1) == 0, W'($urandom));
        end
        for (int i = 0; i < 4; i++) idle();
        check("queues_drained", 32'(exp_q.size() + err_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
